// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg -- configurable oversampling UART receiver with a show-ahead FIFO.
//
// A frame is start bit, DBIT data bits (LSB first), optional parity bit and a
// stop phase of SB_TICK oversampling ticks. Every received frame, including
// frames with parity or framing errors, is pushed into the FIFO together with
// its error flags.
//
// Ports:
//   clk          single clock, all state on its rising edge
//   reset        asynchronous, active-high reset
//   rx           asynchronous serial line, idle high
//   s_tick       one-clk oversampling strobe (OS per bit period)
//   rd_en        pops the FIFO head (ignored while rx_empty)
//   err_clr      clears overrun_err
//   rx_dout      FIFO head data, valid while rx_empty=0
//   rx_perr      parity error flag of the FIFO head word
//   rx_ferr      framing error flag of the FIFO head word
//   rx_empty     FIFO empty
//   rx_full      FIFO full
//   rx_done_tick one-clk pulse per completed frame
//   overrun_err  sticky: a frame was dropped because the FIFO was full
module uart_rx_cfg #(
    parameter int DBIT       = 8,
    parameter int OS         = 16,
    parameter int SB_TICK    = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int FIFO_AW    = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            s_tick,
    input  logic            rd_en,
    input  logic            err_clr,
    output logic [DBIT-1:0] rx_dout,
    output logic            rx_perr,
    output logic            rx_ferr,
    output logic            rx_empty,
    output logic            rx_full,
    output logic            rx_done_tick,
    output logic            overrun_err
);

    localparam int SMAX  = (OS > SB_TICK) ? OS : SB_TICK;
    localparam int SW    = $clog2(SMAX);
    localparam int NW    = $clog2(DBIT);
    localparam int WW    = DBIT + 2;
    localparam int DEPTH = 2 ** FIFO_AW;

    localparam logic [SW-1:0] S_HALF = SW'(OS / 2 - 1);
    localparam logic [SW-1:0] S_BIT  = SW'(OS - 1);
    localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);
    localparam logic          ODD    = (PARITY_ODD != 0);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    // ------------------------------------------------------------------
    // Two-flop synchronizer; resets to the idle (high) line level
    // ------------------------------------------------------------------
    logic rx_meta_reg, rxs_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_reg <= 1'b1;
            rxs_reg     <= 1'b1;
        end else begin
            rx_meta_reg <= rx;
            rxs_reg     <= rx_meta_reg;
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    state_t          state_reg, state_next;
    logic [SW-1:0]   s_reg, s_next;
    logic [NW-1:0]   n_reg, n_next;
    logic [DBIT-1:0] b_reg, b_next;
    logic            perr_reg, perr_next;
    logic            push;
    logic [WW-1:0]   push_word;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            s_reg     <= '0;
            n_reg     <= '0;
            b_reg     <= '0;
            perr_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            s_reg     <= s_next;
            n_reg     <= n_next;
            b_reg     <= b_next;
            perr_reg  <= perr_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        s_next       = s_reg;
        n_next       = n_reg;
        b_next       = b_reg;
        perr_next    = perr_reg;
        push         = 1'b0;
        rx_done_tick = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!rxs_reg) begin
                    state_next = START;
                    s_next     = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_reg == S_HALF) begin
                        // Line must still be low mid start bit, else it was a glitch
                        if (!rxs_reg) begin
                            state_next = DATA;
                            s_next     = '0;
                            n_next     = '0;
                            perr_next  = 1'b0;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        s_next = s_reg + SW'(1);
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_reg == S_BIT) begin
                        s_next = '0;
                        // LSB arrives first, so shift in from the top
                        b_next = {rxs_reg, b_reg[DBIT-1:1]};
                        if (n_reg == N_LAST) begin
                            state_next = (PARITY_EN != 0) ? PARITY : STOP;
                        end else begin
                            n_next = n_reg + NW'(1);
                        end
                    end else begin
                        s_next = s_reg + SW'(1);
                    end
                end
            end
            PARITY: begin
                if (s_tick) begin
                    if (s_reg == S_BIT) begin
                        s_next     = '0;
                        perr_next  = (^b_reg) ^ rxs_reg ^ ODD;
                        state_next = STOP;
                    end else begin
                        s_next = s_reg + SW'(1);
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_reg == S_STOP) begin
                        push         = 1'b1;
                        rx_done_tick = 1'b1;
                        state_next   = IDLE;
                    end else begin
                        s_next = s_reg + SW'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Framing error is taken from the live stop-bit sample
    assign push_word = {~rxs_reg, perr_reg, b_reg};

    // ------------------------------------------------------------------
    // Show-ahead FIFO
    // ------------------------------------------------------------------
    logic [FIFO_AW:0] wr_ptr_reg, rd_ptr_reg;
    logic [WW-1:0]    mem [DEPTH];
    logic [WW-1:0]    head;
    logic             do_read, do_write, drop;
    logic             overrun_reg;

    assign rx_empty = (wr_ptr_reg == rd_ptr_reg);
    assign rx_full  = (wr_ptr_reg[FIFO_AW-1:0] == rd_ptr_reg[FIFO_AW-1:0]) &&
                      (wr_ptr_reg[FIFO_AW] != rd_ptr_reg[FIFO_AW]);

    assign do_read  = rd_en & ~rx_empty;
    // A simultaneous pop frees the slot, so a push is accepted even when full
    assign do_write = push & (~rx_full | do_read);
    assign drop     = push & rx_full & ~do_read;

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr_reg[FIFO_AW-1:0]] <= push_word;
        end
    end

    assign head                        = mem[rd_ptr_reg[FIFO_AW-1:0]];
    assign {rx_ferr, rx_perr, rx_dout} = head;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            overrun_reg <= 1'b0;
        end else begin
            if (do_write) begin
                wr_ptr_reg <= wr_ptr_reg + (FIFO_AW + 1)'(1);
            end
            if (do_read) begin
                rd_ptr_reg <= rd_ptr_reg + (FIFO_AW + 1)'(1);
            end
            // A drop in the same clk as err_clr keeps the flag set
            if (drop) begin
                overrun_reg <= 1'b1;
            end else if (err_clr) begin
                overrun_reg <= 1'b0;
            end
        end
    end

    assign overrun_err = overrun_reg;

endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 SHALL have parameter DBIT, default 8: data bits per frame, legal range 5..9.
REQ-002 SHALL have parameter OS, default 16: s_tick pulses per bit period, even, >=8.
REQ-003 SHALL have parameter SB_TICK, default 16: s_tick pulses in the stop phase (16/24/32 = 1/1.5/2 stop bits at OS=16).
REQ-004 SHALL have parameter PARITY_EN, default 0: 1 inserts a parity bit after the data bits.
REQ-005 SHALL have parameter PARITY_ODD, default 0: 0 = even parity, 1 = odd parity.
REQ-006 SHALL have parameter FIFO_AW, default 2: FIFO depth = 2**FIFO_AW words.
REQ-007 SHALL have port clk  input  1  the single clock; all state on its rising edge.
REQ-008 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-009 SHALL have port rx  input  1  asynchronous serial line; idle high.
REQ-010 SHALL have port s_tick  input  1  one-clk oversampling strobe.
REQ-011 SHALL have port rd_en  input  1  pops the FIFO head.
REQ-012 SHALL have port err_clr  input  1  clears overrun_err.
REQ-013 SHALL have port rx_dout  output  DBIT  FIFO head data; valid only while rx_empty=0.
REQ-014 SHALL have port rx_perr / rx_ferr  output  1 each  parity/framing error flags stored with the FIFO head word.
REQ-015 SHALL have port rx_empty, rx_full  output  1 each  FIFO status.
REQ-016 SHALL have port rx_done_tick  output  1  one-clk pulse per completed frame.
REQ-017 SHALL have port overrun_err  output  1  sticky: a frame was dropped because the FIFO was full.

Function
REQ-018 SHALL pass rx through a 2-flop synchronizer; every FSM sample SHALL use the synchronized value (rxs).
REQ-019 SHALL implement states IDLE, START, DATA, PARITY, STOP, with tick counter s and bit counter n; s and n SHALL advance only on s_tick.
REQ-020 IDLE: rxs=0 -> START with s=0; rxs=1 -> stay.
REQ-021 START: on s_tick with s=OS/2-1, rxs=0 -> DATA (s=0, n=0); rxs=1 -> IDLE, with no push and no pulse (glitch reject).
REQ-022 DATA: on s_tick with s=OS-1, SHALL shift rxs into the MSB of a DBIT-wide register (LSB first on the line) and clear s. After DBIT bits -> PARITY if PARITY_EN=1, else STOP.
REQ-023 PARITY: on s_tick with s=OS-1, perr = XOR(data bits, rxs, PARITY_ODD), i.e. 1 on mismatch -> STOP.
REQ-024 STOP: on s_tick with s=SB_TICK-1, ferr = ~rxs; SHALL push {ferr, perr, data} and assert rx_done_tick for exactly one clk -> IDLE.
REQ-025 perr SHALL be 0 whenever PARITY_EN=0.
REQ-026 The FIFO SHALL be show-ahead: rx_dout/rx_perr/rx_ferr present the oldest word combinationally from the memory at the read pointer.
REQ-027 rd_en while rx_empty=1 SHALL be ignored.
REQ-028 A push while rx_full=1 and rd_en=0 SHALL drop the word and set overrun_err; rx_done_tick SHALL still pulse.
REQ-029 A push with rd_en=1 in the same clk SHALL be accepted even when full; occupancy SHALL be unchanged.
REQ-030 Pointers SHALL be FIFO_AW+1 bits and wrap modulo 2**(FIFO_AW+1); empty = pointers equal; full = addresses equal and MSBs differ.
REQ-031 overrun_err SHALL clear on err_clr unless a drop occurs in the same clk, in which case it SHALL stay set.
REQ-032 Latency: rx_empty SHALL deassert in the clk after rx_done_tick.

Reset
REQ-033 reset=1 SHALL immediately force: state IDLE, s=n=0, synchronizer flops=1, pointers=0, rx_empty=1, rx_full=0, rx_done_tick=0, overrun_err=0; FIFO memory is not reset.
REQ-034 Reset asserted mid-frame SHALL discard the partial frame; after release the FSM SHALL wait in IDLE for the next falling edge.

Verification (s_tick every 16 clk, OS=16, so 1 bit = 256 clk)
REQ-035 Defaults, send 0xA5 8N1 -> one rx_done_tick; rx_dout=8'hA5, rx_perr=0, rx_ferr=0; rd_en -> rx_empty=1.
REQ-036 PARITY_EN=1, even: send 0x03 with parity bit 1 -> rx_dout=8'h03, rx_perr=1; same byte with parity bit 0 -> rx_perr=0.
REQ-037 Send 0x55 with stop bit 0 -> rx_dout=8'h55, rx_ferr=1, rx_done_tick pulses once.
REQ-038 rx low for 4 s_ticks, then high -> no rx_done_tick, rx_empty stays 1; a following 0x3C is received correctly.
REQ-039 FIFO_AW=2: send 0x01..0x05 with no reads -> rx_full=1, overrun_err=1; reads return 0x01..0x04 then rx_empty=1; err_clr -> overrun_err=0.
REQ-040 Assert reset during data bit 3 of 0xFF, release, send 0x81 -> only 0x81 is received, with no error flags.
